// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: bus word, RAM status encoding and
// arbiter FSM states (the latter also used when decoding traces).
package mem_arbiter_pkg;

    localparam int WORD_BITS = 32;

    typedef logic [WORD_BITS-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and RAM-side handshake bundle for the memory arbiter.
// slave = arbiter view, master = environment (caches + RAM) view.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;

    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;

    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates icache fills and dcache reads/writes onto one RAM port.
// Data side has priority; dcount bounds icache starvation to DBURST_MAX grants.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DBURST_MAX = 4,
    parameter int WORD_W     = 32
) (
    input  logic            CLK,
    input  logic            RST,
    mem_arbiter_if.slave    bus
);

    localparam int                CNT_W      = $clog2(DBURST_MAX + 1);
    localparam logic [CNT_W-1:0]  DCOUNT_MAX = CNT_W'(DBURST_MAX);
    localparam logic [WORD_W-1:0] ZERO_WORD  = {WORD_W{1'b0}};

    arb_state_t        state_r;
    arb_state_t        state_next_s;
    logic [CNT_W-1:0]  dcount_r;
    logic [CNT_W-1:0]  dcount_next_s;

    logic              dreq_s;
    logic              access_s;
    logic              iwait_s;
    logic              dwait_s;
    logic              ram_ren_s;
    logic              ram_wen_s;
    logic [WORD_W-1:0] ramaddr_s;
    logic [WORD_W-1:0] ramstore_s;
    logic [WORD_W-1:0] iload_s;
    logic [WORD_W-1:0] dload_s;

    assign dreq_s   = bus.dREN | bus.dWEN;
    assign access_s = (bus.ramstate == ACCESS);

    // Grant state and fairness counter registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r  <= IDLE;
            dcount_r <= {CNT_W{1'b0}};
        end else begin
            state_r  <= state_next_s;
            dcount_r <= dcount_next_s;
        end
    end

    // Next-state selection, fairness update and per-state output decode.
    always_comb begin
        state_next_s  = state_r;
        dcount_next_s = dcount_r;
        iwait_s       = 1'b1;
        dwait_s       = 1'b1;
        ram_ren_s     = 1'b0;
        ram_wen_s     = 1'b0;
        ramaddr_s     = ZERO_WORD;
        ramstore_s    = ZERO_WORD;
        iload_s       = ZERO_WORD;
        dload_s       = ZERO_WORD;

        case (state_r)
            IDLE: begin
                if (!bus.iREN) begin
                    dcount_next_s = {CNT_W{1'b0}};
                end else begin
                    dcount_next_s = dcount_r;
                end

                if (dreq_s && bus.iREN && (dcount_r == DCOUNT_MAX)) begin
                    state_next_s = IGRANT;
                end else if (dreq_s) begin
                    state_next_s = DGRANT;
                end else if (bus.iREN) begin
                    state_next_s = IGRANT;
                end else begin
                    state_next_s = IDLE;
                end
            end

            IGRANT: begin
                // A dropped request abandons the transfer without a completion.
                if (!bus.iREN) begin
                    state_next_s = IDLE;
                end else begin
                    ram_ren_s = 1'b1;
                    ramaddr_s = bus.iaddr;
                    if (access_s) begin
                        iwait_s       = 1'b0;
                        iload_s       = bus.ramload;
                        dcount_next_s = {CNT_W{1'b0}};
                        state_next_s  = IDLE;
                    end else begin
                        state_next_s  = IGRANT;
                    end
                end
            end

            DGRANT: begin
                if (!dreq_s) begin
                    state_next_s = IDLE;
                end else begin
                    ram_wen_s  = bus.dWEN;
                    ram_ren_s  = bus.dREN & ~bus.dWEN;
                    ramaddr_s  = bus.daddr;
                    ramstore_s = bus.dstore;
                    if (access_s) begin
                        dwait_s      = 1'b0;
                        dload_s      = bus.dWEN ? ZERO_WORD : bus.ramload;
                        state_next_s = IDLE;
                        if (bus.iREN && (dcount_r != DCOUNT_MAX)) begin
                            dcount_next_s = dcount_r + CNT_W'(1);
                        end else begin
                            dcount_next_s = dcount_r;
                        end
                    end else begin
                        state_next_s = DGRANT;
                    end
                end
            end

            default: begin
                state_next_s  = IDLE;
                dcount_next_s = {CNT_W{1'b0}};
            end
        endcase
    end

    assign bus.iwait    = iwait_s;
    assign bus.dwait    = dwait_s;
    assign bus.ramREN   = ram_ren_s;
    assign bus.ramWEN   = ram_wen_s;
    assign bus.ramaddr  = ramaddr_s;
    assign bus.ramstore = ramstore_s;
    assign bus.iload    = iload_s;
    assign bus.dload    = dload_s;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: reset, single and contended
// grants, fairness burst, write path, RAM error retry and request abort.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic CLK = 1'b0;
    logic RST;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 CLK = ~CLK;

    mem_arbiter_if bus();

    mem_arbiter #(.DBURST_MAX(4), .WORD_W(32)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled around the negedge.
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    logic [31:0] grant_addr [8];
    logic [31:0] exp_addr   [5];
    int          n_grant;
    int          n_icomp;
    int          n_dcomp;

    initial begin
        RST          = 1'b1;
        bus.iREN     = 1'b0;
        bus.iaddr    = 32'h0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = 32'h0;
        bus.dstore   = 32'h0;
        bus.ramload  = 32'h0;
        bus.ramstate = FREE;
        tick();
        RST = 1'b0;
        #1;
        check("rst_iwait",  32'(bus.iwait),  32'd1);
        check("rst_dwait",  32'(bus.dwait),  32'd1);
        check("rst_ramren", 32'(bus.ramREN), 32'd0);
        check("rst_ramwen", 32'(bus.ramWEN), 32'd0);
        check("rst_addr",   bus.ramaddr,     32'h0);
        check("rst_store",  bus.ramstore,    32'h0);
        check("rst_iload",  bus.iload,       32'h0);
        check("rst_dload",  bus.dload,       32'h0);

        // Lone icache read; RAM answers one cycle after the strobe.
        bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.ramstate = BUSY;
        #1;
        check("i_arb_ramren", 32'(bus.ramREN), 32'd0);
        tick(); #1;
        check("i_c1_ramren", 32'(bus.ramREN), 32'd1);
        check("i_c1_addr",   bus.ramaddr,     32'h40);
        check("i_c1_iwait",  32'(bus.iwait),  32'd1);
        check("i_c1_dwait",  32'(bus.dwait),  32'd1);
        bus.ramstate = ACCESS; bus.ramload = 32'hDEADBEEF;
        #1;
        check("i_c2_iwait", 32'(bus.iwait), 32'd0);
        check("i_c2_iload", bus.iload,      32'hDEADBEEF);
        check("i_c2_dwait", 32'(bus.dwait), 32'd1);
        tick();
        bus.iREN = 1'b0; bus.ramstate = FREE;
        #1;
        check("i_done_ramren", 32'(bus.ramREN), 32'd0);
        check("i_done_iwait",  32'(bus.iwait),  32'd1);

        // Write (dREN&dWEN) granted, then reset while RAM is busy.
        bus.dREN = 1'b1; bus.dWEN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'h12345678;
        bus.ramstate = BUSY;
        tick(); #1;
        check("w_ramwen", 32'(bus.ramWEN), 32'd1);
        check("w_ramren", 32'(bus.ramREN), 32'd0);
        check("w_addr",   bus.ramaddr,     32'h100);
        check("w_store",  bus.ramstore,    32'h12345678);
        check("w_dwait",  32'(bus.dwait),  32'd1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        check("mrst_ramwen", 32'(bus.ramWEN), 32'd0);
        check("mrst_ramren", 32'(bus.ramREN), 32'd0);
        check("mrst_dwait",  32'(bus.dwait),  32'd1);
        check("mrst_iwait",  32'(bus.iwait),  32'd1);
        tick();
        bus.ramstate = ACCESS; bus.ramload = 32'hCAFEF00D;
        #1;
        check("w_cmp_dwait",  32'(bus.dwait),  32'd0);
        check("w_cmp_dload",  bus.dload,       32'h0);
        check("w_cmp_ramwen", 32'(bus.ramWEN), 32'd1);
        check("w_cmp_ramren", 32'(bus.ramREN), 32'd0);
        tick();
        bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.ramstate = FREE;

        // Simultaneous requests: dcache first, icache after.
        bus.iREN = 1'b1; bus.iaddr = 32'h44; bus.dREN = 1'b1; bus.daddr = 32'h200;
        bus.ramstate = ACCESS; bus.ramload = 32'h11111111;
        tick(); #1;
        check("pri_d_addr",  bus.ramaddr,    32'h200);
        check("pri_d_dwait", 32'(bus.dwait), 32'd0);
        check("pri_d_dload", bus.dload,      32'h11111111);
        check("pri_d_iwait", 32'(bus.iwait), 32'd1);
        tick();
        bus.dREN = 1'b0;
        #1;
        check("pri_idle_ramren", 32'(bus.ramREN), 32'd0);
        tick();
        bus.ramload = 32'h22222222;
        #1;
        check("pri_i_addr",  bus.ramaddr,    32'h44);
        check("pri_i_iwait", 32'(bus.iwait), 32'd0);
        check("pri_i_iload", bus.iload,      32'h22222222);
        check("pri_i_dwait", 32'(bus.dwait), 32'd1);
        tick();
        bus.iREN = 1'b0;

        // Fairness: continuous dcache traffic with icache pending.
        exp_addr[0] = 32'h300; exp_addr[1] = 32'h300; exp_addr[2] = 32'h300;
        exp_addr[3] = 32'h300; exp_addr[4] = 32'h80;
        n_grant = 0; n_icomp = 0; n_dcomp = 0;
        bus.iREN = 1'b1; bus.iaddr = 32'h80; bus.dREN = 1'b1; bus.daddr = 32'h300;
        bus.ramload = 32'h33333333;
        for (int k = 0; k < 10; k++) begin
            tick(); #1;
            if (bus.ramREN) begin
                if (n_grant < 8) grant_addr[n_grant] = bus.ramaddr;
                n_grant++;
            end
            if (!bus.iwait) n_icomp++;
            if (!bus.dwait) n_dcomp++;
        end
        check("fair_grants", 32'(n_grant), 32'd5);
        check("fair_dcomp",  32'(n_dcomp), 32'd4);
        check("fair_icomp",  32'(n_icomp), 32'd1);
        for (int g = 0; g < 5; g++) begin
            check($sformatf("fair_addr%0d", g), (g < n_grant) ? grant_addr[g] : 32'hXXXXXXXX,
                  exp_addr[g]);
        end
        bus.iREN = 1'b0; bus.dREN = 1'b0; bus.ramstate = FREE;
        tick();

        // RAM error retry with a new dcache request that must not preempt.
        bus.iREN = 1'b1; bus.iaddr = 32'h60; bus.ramstate = ERROR;
        tick();
        bus.dREN = 1'b1; bus.daddr = 32'h500;
        for (int e = 0; e < 3; e++) begin
            #1;
            check($sformatf("err%0d_ramren", e), 32'(bus.ramREN), 32'd1);
            check($sformatf("err%0d_addr", e),   bus.ramaddr,     32'h60);
            check($sformatf("err%0d_iwait", e),  32'(bus.iwait),  32'd1);
            check($sformatf("err%0d_dwait", e),  32'(bus.dwait),  32'd1);
            tick();
        end
        bus.ramstate = ACCESS; bus.ramload = 32'hA5A5A5A5;
        #1;
        check("err_cmp_iwait", 32'(bus.iwait), 32'd0);
        check("err_cmp_iload", bus.iload,      32'hA5A5A5A5);
        bus.dREN = 1'b0;
        tick();
        bus.iREN = 1'b0; bus.ramstate = FREE;
        tick();

        // Abort: icache drops its request while RAM is busy.
        bus.iREN = 1'b1; bus.iaddr = 32'h64; bus.ramstate = BUSY;
        tick(); #1;
        check("abt_grant_ramren", 32'(bus.ramREN), 32'd1);
        bus.iREN = 1'b0;
        #1;
        check("abt_ramren", 32'(bus.ramREN), 32'd0);
        check("abt_iwait",  32'(bus.iwait),  32'd1);
        tick();
        bus.ramstate = ACCESS;
        #1;
        check("abt_idle_ramren", 32'(bus.ramREN), 32'd0);
        check("abt_idle_iwait",  32'(bus.iwait),  32'd1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
